// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores bytes into a small FIFO,
// a four-state FSM serialises them LSB first on a registered tx line.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] DATA_ADDR    = 32'hFFFF_FC70,
    parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_FC74
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_we,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        tx
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Handshake: the CPU side has no ready; a store at DATA_ADDR is taken
    // when the FIFO has room (or a pop frees a slot that cycle), else dropped
    // and flagged in the sticky overflow bit.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;

    logic empty, full, busy, baud_end;
    logic push_req, push, pop, drop, clr_ovf;
    logic unused_bits;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign busy     = (state_q != IDLE);
    assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

    assign push_req = io_we && (io_addr == DATA_ADDR);
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign clr_ovf  = io_we && (io_addr == STATUS_ADDR) && io_write_data[3];

    assign unused_bits = ^io_write_data[31:8];

    always_comb begin
        io_read_data = 32'b0;
        if (io_addr == STATUS_ADDR) begin
            io_read_data[3:0] = {overflow, busy, full, empty};
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = mem[rd_ptr];
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    sh_d   = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= io_write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign tx = tx_q;

endmodule
